// File: rtl/jpeg_uart_tx_if.sv
// Byte stream from the JPEG encoder into the UART sink: one byte per strobe, no backpressure.
interface jpeg_uart_tx_if;
    logic       send_data_vaild;
    logic       send_data_last;
    logic [7:0] send_data;

    modport master (output send_data_vaild, output send_data_last, output send_data);
    modport slave  (input  send_data_vaild, input  send_data_last, input  send_data);
endinterface

// File: rtl/jpeg_uart_tx.sv
// Buffers the encoder byte stream in a {last,data} FIFO and serialises it as 8N1 UART,
// with sticky overflow detection and an end-of-frame pulse after the last byte's stop bit.
module jpeg_uart_tx #(
    parameter int CLK_FRE    = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 4096
) (
    input  logic           clk,
    input  logic           rst_n,
    jpeg_uart_tx_if.slave  enc,
    output logic           uart_tx,
    output logic           tx_busy,
    output logic           fifo_overflow,
    output logic           frame_done
);
    localparam int AW         = $clog2(FIFO_DEPTH);
    localparam int PW         = AW + 1;
    localparam int BIT_CYCLES = CLK_FRE / BAUD_RATE;
    localparam int CW         = $clog2(BIT_CYCLES);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [8:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PW-1:0] fill;
    logic          full, empty, wr_en, pop;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg;
    logic [2:0]    bit_idx_reg;
    logic [7:0]    shift_reg;
    logic          last_reg;
    logic          bit_end;
    logic          uart_tx_reg, uart_tx_next;
    logic          frame_done_reg, frame_done_next;
    logic          overflow_reg;

    // Status comes from registered pointers only, so a same-cycle pop never frees room for a write.
    assign fill  = wr_ptr_reg - rd_ptr_reg;
    assign full  = (fill == PW'(FIFO_DEPTH));
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign wr_en = enc.send_data_vaild && !full;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr_reg[AW-1:0]] <= {enc.send_data_last, enc.send_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            if (enc.send_data_vaild && full)
                overflow_reg <= 1'b1;
        end
    end

    // Registered RAM read: the popped entry lands directly in the shift register.
    always_ff @(posedge clk) begin
        if (pop) begin
            shift_reg <= mem[rd_ptr_reg[AW-1:0]][7:0];
            last_reg  <= mem[rd_ptr_reg[AW-1:0]][8];
        end
    end

    assign bit_end = (cnt_reg == CW'(BIT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (!empty)                         state_next = START;
            START:   if (bit_end)                        state_next = DATA;
            DATA:    if (bit_end && bit_idx_reg == 3'd7) state_next = STOP;
            STOP:    if (bit_end)                        state_next = IDLE;
            default:                                     state_next = IDLE;
        endcase
    end

    always_comb begin
        pop             = 1'b0;
        uart_tx_next    = 1'b1;
        frame_done_next = 1'b0;
        case (state_reg)
            IDLE:    pop             = !empty;
            START:   uart_tx_next    = 1'b0;
            DATA:    uart_tx_next    = shift_reg[bit_idx_reg];
            STOP:    frame_done_next = bit_end && last_reg;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg        <= '0;
            bit_idx_reg    <= '0;
            uart_tx_reg    <= 1'b1;
            frame_done_reg <= 1'b0;
        end else begin
            uart_tx_reg    <= uart_tx_next;
            frame_done_reg <= frame_done_next;
            if (state_reg == IDLE || bit_end)
                cnt_reg <= '0;
            else
                cnt_reg <= cnt_reg + CW'(1);
            // Index wraps 7 -> 0 naturally as DATA hands over to STOP.
            if (state_reg == START)
                bit_idx_reg <= '0;
            else if (state_reg == DATA && bit_end)
                bit_idx_reg <= bit_idx_reg + 3'd1;
        end
    end

    assign uart_tx       = uart_tx_reg;
    assign frame_done    = frame_done_reg;
    assign fifo_overflow = overflow_reg;
    assign tx_busy       = !empty || (state_reg != IDLE);
endmodule

// File: tb/tb_jpeg_uart_tx.sv
// Directed bench for jpeg_uart_tx: a timeline model of the UART line checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_jpeg_uart_tx;
    localparam int BC    = 10;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic uart_tx, tx_busy, fifo_overflow, frame_done;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   fd_count = 0;

    jpeg_uart_tx_if bus ();

    jpeg_uart_tx #(.CLK_FRE(1_000_000), .BAUD_RATE(100_000), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enc           (bus.master),
        .uart_tx       (uart_tx),
        .tx_busy       (tx_busy),
        .fifo_overflow (fifo_overflow),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: accepted bytes in a queue; the character on the line is a start edge plus a frame.
    logic [8:0] mq[$];
    bit         m_active = 0;
    int         m_start = 0;
    logic [7:0] m_byte = 8'h00;
    bit         m_last = 0;
    bit         m_ovf = 0;

    initial begin
        forever begin
            int k, pre_size, off, bi, done_edge;
            logic v, l, exp_tx, exp_busy, exp_fd;
            logic [7:0] d;
            logic [8:0] ent;
            @(posedge clk);
            k = cyc;
            v = bus.send_data_vaild; l = bus.send_data_last; d = bus.send_data;
            if (!rst_n) begin
                mq.delete(); m_active = 0; m_ovf = 0;
            end else begin
                pre_size = mq.size();
                if ((!m_active || k >= m_start + 10*BC + 1) && pre_size > 0) begin
                    ent = mq.pop_front();
                    m_active = 1; m_start = k; m_byte = ent[7:0]; m_last = ent[8];
                end
                if (v) begin
                    if (pre_size >= DEPTH) m_ovf = 1;
                    else mq.push_back({l, d});
                end
            end
            #1;
            done_edge = m_start + 10*BC;
            off = k - m_start - 1;
            exp_tx = 1'b1;
            if (m_active && off >= 0 && off < 10*BC) begin
                bi = off / BC;
                if (bi == 0) exp_tx = 1'b0;
                else if (bi <= 8) exp_tx = m_byte[bi-1];
            end
            exp_busy = (mq.size() > 0) || (m_active && k < done_edge);
            exp_fd   = m_active && (k == done_edge) && m_last;
            check("uart_tx", uart_tx, exp_tx);
            check("tx_busy", tx_busy, exp_busy);
            check("fifo_overflow", fifo_overflow, m_ovf);
            check("frame_done", frame_done, exp_fd);
            if (frame_done === 1'b1) fd_count++;
        end
    end

    task automatic send(input logic [7:0] b, input logic last, output int e);
        @(negedge clk);
        bus.send_data_vaild = 1'b1; bus.send_data_last = last; bus.send_data = b;
        e = cyc;
        $display("write byte %02h last=%0d at edge %0d", b, last, e);
    endtask

    task automatic stop_send();
        @(negedge clk);
        bus.send_data_vaild = 1'b0; bus.send_data_last = 1'b0; bus.send_data = 8'h00;
    endtask

    task automatic at_edge(input int e);
        while (1) begin
            @(posedge clk);
            if (cyc >= e) break;
        end
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (tx_busy !== 1'b0 && n < 3000) begin
            @(posedge clk); #1; n++;
        end
        check("idle_timeout", tx_busy, 1'b0);
        repeat (5) @(posedge clk);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, e;
        bus.send_data_vaild = 1'b0; bus.send_data_last = 1'b0; bus.send_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_uart_tx", uart_tx, 1'b1);
        check("rst_tx_busy", tx_busy, 1'b0);
        check("rst_overflow", fifo_overflow, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Single byte 0xA5: bits LSB first 1,0,1,0,0,1,0,1
        fd_count = 0;
        send(8'hA5, 1'b0, e0); stop_send();
        at_edge(e0+1);   check("a5_busy_e1", tx_busy, 1'b1); check("a5_tx_e1", uart_tx, 1'b1);
        at_edge(e0+2);   check("a5_start_first", uart_tx, 1'b0);
        at_edge(e0+11);  check("a5_start_last", uart_tx, 1'b0);
        at_edge(e0+12);  check("a5_bit0", uart_tx, 1'b1);
        at_edge(e0+22);  check("a5_bit1", uart_tx, 1'b0);
        at_edge(e0+32);  check("a5_bit2", uart_tx, 1'b1);
        at_edge(e0+82);  check("a5_bit7", uart_tx, 1'b1);
        at_edge(e0+92);  check("a5_stop", uart_tx, 1'b1);
        at_edge(e0+100); check("a5_busy_stop", tx_busy, 1'b1);
        at_edge(e0+101); check("a5_busy_done", tx_busy, 1'b0);
        wait_idle();
        check("a5_no_frame_done", fd_count, 0);

        // Burst: start bits 101 cycles apart
        send(8'h00, 1'b0, e0); send(8'hFF, 1'b0, e); send(8'h55, 1'b0, e); stop_send();
        at_edge(e0+102); check("burst_gap", uart_tx, 1'b1);
        at_edge(e0+103); check("burst_start2", uart_tx, 1'b0);
        at_edge(e0+113); check("burst_ff_bit0", uart_tx, 1'b1);
        at_edge(e0+203); check("burst_gap2", uart_tx, 1'b1);
        at_edge(e0+204); check("burst_start3", uart_tx, 1'b0);
        at_edge(e0+214); check("burst_55_bit0", uart_tx, 1'b1);
        at_edge(e0+224); check("burst_55_bit1", uart_tx, 1'b0);
        wait_idle();
        check("burst_no_overflow", fifo_overflow, 1'b0);

        // Overflow: six bytes, sixth dropped
        send(8'h11, 1'b0, e0);
        for (int i = 2; i <= 6; i++) send(8'(8'h10 + i), 1'b0, e);
        check("ovf_before_drop", fifo_overflow, 1'b0);
        stop_send();
        check("ovf_after_drop", fifo_overflow, 1'b1);
        at_edge(e0+406); check("ovf_byte5_start", uart_tx, 1'b0);
        at_edge(e0+507); check("ovf_no_byte6", uart_tx, 1'b1);
        at_edge(e0+510); check("ovf_drained_busy", tx_busy, 1'b0);
        check("ovf_sticky", fifo_overflow, 1'b1);
        wait_idle();

        // Last flag on the second byte
        fd_count = 0;
        send(8'hFF, 1'b0, e0); send(8'hD9, 1'b1, e); stop_send();
        at_edge(e0+201); check("last_fd_before", frame_done, 1'b0);
        at_edge(e0+202); check("last_fd_pulse", frame_done, 1'b1);
        at_edge(e0+203); check("last_fd_after", frame_done, 1'b0);
        wait_idle();
        check("last_fd_count", fd_count, 1);

        // Reset during DATA bit 3 with two bytes queued
        send(8'h00, 1'b0, e0); send(8'h3C, 1'b0, e); send(8'h81, 1'b0, e); stop_send();
        at_edge(e0+45);
        check("rst_mid_line_low", uart_tx, 1'b0);
        check("rst_mid_ovf_pre", fifo_overflow, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        check("rst_mid_uart_tx", uart_tx, 1'b1);
        check("rst_mid_tx_busy", tx_busy, 1'b0);
        check("rst_mid_overflow", fifo_overflow, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        check("post_rst_line", uart_tx, 1'b1);
        check("post_rst_busy", tx_busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
